display_frame_decoder: RTL

- Receive-side decoder for the multiplexed 7-segment display bus driven by the clock sequencer (D, Digit, DP).
- Tracks the 4-slot digit rotation and reassembles a coherent HH:MM time.
- Checks bus protocol and flags violations.
- Used as an on-chip self-check / readback block and as the bench's bus monitor.

---
 rtl/display_frame_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/display_frame_decoder.sv
// display_frame_decoder
// Receive-side decoder for the multiplexed 7-segment display bus (D, Digit, DP).
// Follows the 4-slot digit rotation H10 -> H1 -> M10 -> M1, reassembles HH:MM,
// flags protocol violations and reports lock once enough clean frames are seen.
//
// Optional build macro: DISPLAY_RANGE_CHECK_EN
//   When defined, the frame is value-checked at the M1 commit (BCD ranges and
//   12-hour legality); a failed check is handled exactly like a protocol error.
//
// State table:
//   state | meaning
//   HUNT  | not locked; waiting for a 0001 (M1) anode sample to align on
//   S_H10 | expecting hours-tens slot (1000 with D=1, or 0000 blank), DP high
//   S_H1  | expecting hours-units slot (0100), DP low (colon lit)
//   S_M10 | expecting minutes-tens slot (0010), DP high, D[3] clear
//   S_M1  | expecting minutes-units slot (0001), DP high; commit on success

module display_frame_decoder #(
  parameter int ERR_W         = 8,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       D,
  input  logic [3:0]       Digit,
  input  logic             DP,
  output logic             Hour10,
  output logic [3:0]       Hour1,
  output logic [2:0]       Min10,
  output logic [3:0]       Min1,
  output logic             FrameValid,
  output logic             TimeChanged,
  output logic             Valid,
  output logic             ProtoErr,
  output logic [ERR_W-1:0] ErrCount
);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    S_H10 = 3'd1,
    S_H1  = 3'd2,
    S_M10 = 3'd3,
    S_M1  = 3'd4
  } state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_FRAMES);

  state_t     state;
  state_t     state_nxt;

  logic       sample_err;
  logic       commit;
  logic       ld_h10;
  logic       h10_val;
  logic       ld_h1;
  logic       ld_m10;
  logic       range_ok;

  logic       cap_h10;
  logic [3:0] cap_h1;
  logic [2:0] cap_m10;
  logic [3:0] stable_cnt;

`ifdef DISPLAY_RANGE_CHECK_EN
  // Frame value check: BCD ranges plus a legal 12-hour clock reading (1..12).
  assign range_ok = (cap_h1 <= 4'd9) && (cap_m10 <= 3'd5) && (D <= 4'd9) &&
                    (cap_h10 ? (cap_h1 <= 4'd2) : (cap_h1 >= 4'd1));
`else
  assign range_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // Slot expectation check and next-state decode.
  always_comb begin
    state_nxt  = state;
    sample_err = 1'b0;
    commit     = 1'b0;
    ld_h10     = 1'b0;
    h10_val    = 1'b0;
    ld_h1      = 1'b0;
    ld_m10     = 1'b0;
    case (state)
      HUNT: begin
        if (Digit == 4'b0001) state_nxt = S_H10;
      end
      S_H10: begin
        if (DP && (Digit == 4'b1000) && (D == 4'b0001)) begin
          ld_h10    = 1'b1;
          h10_val   = 1'b1;
          state_nxt = S_H1;
        end else if (DP && (Digit == 4'b0000)) begin
          ld_h10    = 1'b1;
          h10_val   = 1'b0;
          state_nxt = S_H1;
        end else begin
          sample_err = 1'b1;
        end
      end
      S_H1: begin
        if (!DP && (Digit == 4'b0100)) begin
          ld_h1     = 1'b1;
          state_nxt = S_M10;
        end else begin
          sample_err = 1'b1;
        end
      end
      S_M10: begin
        if (DP && (Digit == 4'b0010) && !D[3]) begin
          ld_m10    = 1'b1;
          state_nxt = S_M1;
        end else begin
          sample_err = 1'b1;
        end
      end
      S_M1: begin
        if (DP && (Digit == 4'b0001) && range_ok) begin
          commit    = 1'b1;
          state_nxt = S_H10;
        end else begin
          sample_err = 1'b1;
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase
    if (sample_err) state_nxt = HUNT;
  end

  // Partial-frame capture registers; a new frame overwrites them slot by slot.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cap_h10 <= 1'b0;
      cap_h1  <= 4'd0;
      cap_m10 <= 3'd0;
    end else begin
      if (ld_h10) cap_h10 <= h10_val;
      if (ld_h1)  cap_h1  <= D;
      if (ld_m10) cap_m10 <= D[2:0];
    end
  end

  // Committed time and the commit / change / error pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Hour10      <= 1'b1;
      Hour1       <= 4'd2;
      Min10       <= 3'd0;
      Min1        <= 4'd0;
      FrameValid  <= 1'b0;
      TimeChanged <= 1'b0;
      ProtoErr    <= 1'b0;
    end else begin
      FrameValid  <= commit;
      ProtoErr    <= sample_err;
      TimeChanged <= commit &&
                     ({cap_h10, cap_h1, cap_m10, D} != {Hour10, Hour1, Min10, Min1});
      if (commit) begin
        Hour10 <= cap_h10;
        Hour1  <= cap_h1;
        Min10  <= cap_m10;
        Min1   <= D;
      end
    end
  end

  // Saturating error counter and stable-frame counter; any error drops lock.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ErrCount   <= '0;
      stable_cnt <= 4'd0;
    end else begin
      if (sample_err && (ErrCount != '1)) ErrCount <= ErrCount + ERR_W'(1);
      if (sample_err)
        stable_cnt <= 4'd0;
      else if (commit && (stable_cnt != STABLE_MAX))
        stable_cnt <= stable_cnt + 4'd1;
    end
  end

  assign Valid = (stable_cnt == STABLE_MAX);

endmodule
